// File: rtl/fft_ctrl_pkg.sv
// Shared definitions for the FFT run sequencer: state encoding, error
// cause codes and the per-frame beat derivation.
package fft_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LOAD   = 3'd1,
        ST_READY  = 3'd2,
        ST_RUN    = 3'd3,
        ST_UNLOAD = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERROR  = 3'd6
    } state_e;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_INIT    = 2'd1;
    localparam logic [1:0] ERR_LOAD_TO = 2'd2;
    localparam logic [1:0] ERR_RUN_TO  = 2'd3;

    // Beats needed to move one frame, NUMLANES samples per beat.
    function automatic int beats_f(input int num_samples, input int num_lanes);
        return num_samples / num_lanes;
    endfunction

    // Width of the beat index; never narrower than one bit.
    function automatic int idx_w_f(input int beats);
        return (beats > 1) ? $clog2(beats) : 1;
    endfunction

endpackage

// File: rtl/fft_watchdog.sv
// Per-phase watchdog. Counts cycles while active and flags expiry on the
// TIMEOUT-th cycle since the last clear. TIMEOUT=0 disables it entirely.
module fft_watchdog #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic active,
    output logic expired
);

    generate
        if (TIMEOUT == 0) begin : g_off
            logic unused_in;
            assign unused_in = clk ^ rst ^ clr ^ active;
            assign expired   = 1'b0;
        end else begin : g_on
            localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
            localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT - 1);

            logic [CW-1:0] cnt_q, cnt_d;

            // Next count: clear on phase entry, saturate at the limit.
            always_comb begin
                cnt_d = cnt_q;
                if (clr) begin
                    cnt_d = '0;
                end else if (active && (cnt_q != LIMIT)) begin
                    cnt_d = cnt_q + CW'(1);
                end
            end

            // Cycle counter register.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    cnt_q <= '0;
                end else begin
                    cnt_q <= cnt_d;
                end
            end

            assign expired = active && (cnt_q == LIMIT);
        end
    endgenerate

endmodule

// File: rtl/fft_run_ctrl.sv
// Run sequencer for the FFT core: loads the input RAM, enables the core,
// then unloads the result as a beat stream, for one or more frames.
//
// Unload handshake: a beat transfers on a cycle where out_valid and
// out_ready are both high. While out_ready is low, out_valid, out_last and
// beat_idx hold their values and no beat is consumed.
module fft_run_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int WORDSIZE   = 16,
    parameter int NUMLANES   = 4,
    parameter int NUMSAMPLES = 32,
    parameter int NUMSTAGES  = 5,
    parameter int FRAMEW     = 8,
    parameter int TIMEOUT    = 1024,
    localparam int BEATS     = beats_f(NUMSAMPLES, NUMLANES),
    localparam int BIW       = idx_w_f(BEATS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              clear_err,
    input  logic              cont_mode,
    input  logic [FRAMEW-1:0] num_frames,
    input  logic              ld_done,
    input  logic              init_error,
    input  logic              fft_done,
    input  logic              out_ready,
    output logic              ld_data,
    output logic              en,
    output logic              out_valid,
    output logic              out_last,
    output logic [BIW-1:0]    beat_idx,
    output logic [FRAMEW-1:0] frame_cnt,
    output logic              frame_done,
    output logic              busy,
    output logic              all_done,
    output logic              err,
    output logic [1:0]        err_code
);

    localparam int FW1 = FRAMEW + 1;
    // Datapath width and stage count only describe the attached core.
    localparam int unused_cfg = WORDSIZE + NUMSTAGES;

    state_e            state_q, state_d;
    logic [BIW-1:0]    beat_q, beat_d;
    logic [FRAMEW-1:0] fcnt_q, fcnt_d;
    logic [FRAMEW-1:0] frames_q, frames_d;
    logic [1:0]        code_q, code_d;
    logic              fdone_q, fdone_d;

    logic              wd_clr, wd_active, wd_expired;
    logic              beat_last, beat_acc, last_acc, more_frames;
    logic [FW1-1:0]    next_cnt_ext;

    assign beat_last    = (beat_q == BIW'(BEATS - 1));
    assign beat_acc     = (state_q == ST_UNLOAD) && out_ready && !abort;
    assign last_acc     = beat_acc && beat_last;
    assign next_cnt_ext = {1'b0, fcnt_q} + FW1'(1);
    assign more_frames  = next_cnt_ext < {1'b0, frames_q};

    // The watchdog restarts on every state change and only runs in LOAD/RUN.
    assign wd_clr    = (state_d != state_q);
    assign wd_active = (state_q == ST_LOAD) || (state_q == ST_RUN);

    fft_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wd (
        .clk     (clk),
        .rst     (rst),
        .clr     (wd_clr),
        .active  (wd_active),
        .expired (wd_expired)
    );

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and error cause; abort overrides everything outside IDLE.
    always_comb begin
        state_d = state_q;
        code_d  = code_q;
        if (abort && (state_q != ST_IDLE)) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) state_d = ST_LOAD;
                end
                ST_LOAD: begin
                    if (init_error) begin
                        state_d = ST_ERROR;
                        code_d  = ERR_INIT;
                    end else if (ld_done) begin
                        state_d = ST_READY;
                    end else if (wd_expired) begin
                        state_d = ST_ERROR;
                        code_d  = ERR_LOAD_TO;
                    end
                end
                ST_READY: begin
                    state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (fft_done) begin
                        state_d = ST_UNLOAD;
                    end else if (wd_expired) begin
                        state_d = ST_ERROR;
                        code_d  = ERR_RUN_TO;
                    end
                end
                ST_UNLOAD: begin
                    // cont_mode only matters at the frame boundary.
                    if (last_acc) begin
                        state_d = (cont_mode || more_frames) ? ST_LOAD : ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (!start) state_d = ST_IDLE;
                end
                ST_ERROR: begin
                    if (clear_err) state_d = ST_IDLE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
        if (state_d != ST_ERROR) code_d = ERR_NONE;
    end

    // Beat index, frame counters and completion pulse.
    always_comb begin
        beat_d   = beat_q;
        fcnt_d   = fcnt_q;
        frames_d = frames_q;
        fdone_d  = last_acc;
        if ((state_q == ST_IDLE) && start) begin
            frames_d = (num_frames == '0) ? FRAMEW'(1) : num_frames;
            fcnt_d   = '0;
        end
        if (beat_acc) beat_d = beat_q + BIW'(1);
        if (last_acc) fcnt_d = fcnt_q + FRAMEW'(1);
        if (state_d != ST_UNLOAD) beat_d = '0;
    end

    // Datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_q   <= '0;
            fcnt_q   <= '0;
            frames_q <= '0;
            code_q   <= ERR_NONE;
            fdone_q  <= 1'b0;
        end else begin
            beat_q   <= beat_d;
            fcnt_q   <= fcnt_d;
            frames_q <= frames_d;
            code_q   <= code_d;
            fdone_q  <= fdone_d;
        end
    end

    // Phase outputs decoded from the registered state.
    always_comb begin
        ld_data   = 1'b0;
        en        = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        busy      = 1'b1;
        all_done  = 1'b0;
        err       = 1'b0;
        case (state_q)
            ST_IDLE:   busy = 1'b0;
            ST_LOAD:   ld_data = 1'b1;
            ST_RUN:    en = 1'b1;
            ST_UNLOAD: begin
                out_valid = 1'b1;
                out_last  = beat_last;
            end
            ST_DONE:   all_done = 1'b1;
            ST_ERROR: begin
                busy = 1'b0;
                err  = 1'b1;
            end
            default:   busy = 1'b1;
        endcase
    end

    assign beat_idx   = beat_q;
    assign frame_cnt  = fcnt_q;
    assign frame_done = fdone_q;
    assign err_code   = code_q;

endmodule

// File: doc/fft_run_ctrl.md
Name: fft_run_ctrl

Overview:
Synthesizable run sequencer for the FFT core. It replaces the testbench-style IDLE/LDRAM/RAMRDY/RUNNING/DONE flow with a reusable controller. Per frame it drives the input-RAM loader and FFT enable, then unloads results over a valid/ready beat stream. It is generalised in lane count, sample count and stage count, and adds multi-frame and continuous modes, per-phase watchdog, error reporting and abort. It sits between system control and the read_input/fft pair.

Parameters:
WORDSIZE, 16, data word width (passed through to the datapath; sets no logic here)
NUMLANES, 4, samples moved per beat
NUMSAMPLES, 32, samples per frame; must be a multiple of NUMLANES
NUMSTAGES, 5, FFT stages; log2(NUMSAMPLES), informational
FRAMEW, 8, width of the frame-count fields
TIMEOUT, 1024, watchdog limit in cycles for LOAD and RUN; 0 disables the watchdog
BEATS, NUMSAMPLES/NUMLANES, derived; not overridable

Ports:
clk  in  1  system clock; all logic on posedge
rst  in  1  asynchronous, active-high reset
start  in  1  level; request a run
abort  in  1  level; cancel the run, highest priority
clear_err  in  1  pulse; leave ERROR
cont_mode  in  1  live; when 1, loop frames indefinitely
num_frames  in  FRAMEW  frames per run; latched on start; 0 is treated as 1
ld_done  in  1  loader finished
init_error  in  1  loader failure
fft_done  in  1  FFT core finished
out_ready  in  1  downstream accepts a beat
ld_data  out  1  loader request
en  out  1  FFT core enable
out_valid  out  1  unload beat valid
out_last  out  1  final beat of the frame
beat_idx  out  $clog2(BEATS)  unload beat index, used as the RAM read address
frame_cnt  out  FRAMEW  frames completed in this run
frame_done  out  1  one-cycle pulse per completed frame
busy  out  1  high in every state except IDLE and ERROR
all_done  out  1  run complete
err  out  1  in ERROR
err_code  out  2  error cause: 0 none, 1 init_error, 2 load timeout, 3 run timeout

Behaviour:
- Reset: all outputs are 0 and the state is IDLE. Reset mid-operation aborts immediately with no frame_done pulse.
- All outputs are registered and are a function of the current state.
- IDLE: if start=1, latch num_frames, clear frame_cnt, go to LOAD.
- LOAD: ld_data=1.
  - init_error → ERROR, err_code=1. If ld_done and init_error arrive in the same cycle, the error wins.
  - ld_done → READY.
  - Watchdog expiry → ERROR, err_code=2.
- READY: exactly 1 cycle, ld_data=0, then go to RUN.
- RUN: en=1.
  - fft_done → UNLOAD.
  - Watchdog expiry → ERROR, err_code=3. If fft_done and expiry arrive in the same cycle, fft_done wins.
- UNLOAD: out_valid=1.
  - beat_idx starts at 0 and increments only when out_valid&&out_ready.
  - out_last=1 when beat_idx=BEATS-1.
  - out_ready=0 holds everything unchanged; the watchdog is inactive here.
  - On the last accepted beat: pulse frame_done, increment frame_cnt (wraps at 2^FRAMEW).
  - Next state after the last beat: LOAD if cont_mode=1 or frame_cnt+1 < latched frames; otherwise DONE.
  - cont_mode is sampled only at this point.
- DONE: all_done=1, held until start=0, then go to IDLE.
- ERROR: err=1 and err_code held; ld_data=0, en=0, out_valid=0. clear_err → IDLE, which clears err and err_code.
- abort=1 in any state other than IDLE: go to IDLE next cycle, all outputs drop, no frame_done pulse, frame_cnt is held until the next start.
- Watchdog: counter cleared on every state entry. Expiry is when count=TIMEOUT-1 in LOAD or RUN.
- Latency: start to ld_data high is 1 cycle; fft_done to first out_valid is 1 cycle; last beat to ld_data (continuous mode) is 1 cycle.

Decomposition:
- Shared package/include fft_ctrl_pkg:
  - state encoding: IDLE, LOAD, READY, RUN, UNLOAD, DONE, ERROR (3-bit)
  - err_code constants
  - BEATS derivation helper
- One sub-module fft_watchdog, parameter TIMEOUT:
  - inputs: clk, rst, clr, active
  - output: expired
  - with TIMEOUT=0, expired is tied to 0

Test Plan:
- Single frame: num_frames=1, ld_done after 10 cycles, fft_done after 50 cycles, out_ready=1 → 8 beats with beat_idx 0..7, out_last on beat 7, one frame_done, all_done=1, frame_cnt=1.
- Backpressure: out_ready toggles every cycle → 8 accepted beats over 16 cycles; beat_idx stalls while out_ready=0; no watchdog error.
- Multi-frame and continuous: num_frames=3 → 3 frame_done pulses and frame_cnt=3. cont_mode=1 for 4 frames, dropped during frame 5 → exactly 5 frames completed.
- Errors: init_error together with ld_done → err_code=1. TIMEOUT=16 with no fft_done → err_code=3 at cycle 16 of RUN. clear_err → IDLE with err=0.
- Abort: abort at beat 4 of UNLOAD → next cycle IDLE, out_valid=0, no frame_done pulse. start=1 again → clean run.
- Reset: rst asserted mid-RUN asynchronously → en=0 immediately, state IDLE, all outputs 0.
